arith_crypt_seq: RTL and testbench

Byte-serial command sequencer for the arithmetic cipher core inside `tt_um_arythcrypto`. It takes a command header and optional key and payload bytes from the host byte port. It drives the core one byte per operation and returns each result byte through a ready/valid output port. It also enforces a per-operation timeout and reports busy/error status to the top-level pins.

---
 rtl/arith_crypt_seq.sv | 207 ++++++++++++++++++++
 tb/tb_arith_crypt_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_crypt_seq.sv
// -----------------------------------------------------------------------------
// arith_crypt_seq
//
// Byte-serial command sequencer for the arithmetic cipher core. The host
// streams a header byte, an optional 4-byte key (LSB first), then 1..16
// payload bytes. Each payload byte is handed to the core as one operation.
// Each result byte is returned through a ready/valid output port. A
// per-operation timeout aborts the command and raises a sticky error flag.
//
// Header byte: [7] mode (0 enc / 1 dec), [6] key load, [5] clear error,
//              [4] ignored, [3:0] payload length minus one.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   in_data/valid/ready   : host input byte stream (header, key, payload)
//   out_data/valid/ready  : result byte stream back to the host
//   core_start            : one-cycle start pulse to the core
//   core_mode             : operation mode, stable for the whole command
//   core_key              : committed 32-bit key (never partially loaded)
//   core_din              : registered operand byte
//   core_dout, core_done  : core result and its one-cycle completion pulse
//   busy                  : sequencer is not idle
//   err                   : sticky timeout flag
// -----------------------------------------------------------------------------
module arith_crypt_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        core_start,
  output logic        core_mode,
  output logic [31:0] core_key,
  output logic [7:0]  core_din,
  input  logic [7:0]  core_dout,
  input  logic        core_done,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_DATA,
    S_START,
    S_BUSY,
    S_OUT
  } state_t;

  // The counter holds the number of BUSY cycles already completed.
  // The cycle in which it equals LIMIT is therefore the TIMEOUT-th cycle in
  // BUSY. A core_done arriving in that cycle still wins over the timeout.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [3:0]  remain_reg;
  logic [1:0]  key_idx_reg;
  logic [7:0]  cnt_reg;
  logic [7:0]  key_shadow_reg [4];
  logic [31:0] key_reg;
  logic        mode_reg;
  logic        err_reg;
  logic [7:0]  out_data_reg;
  logic [7:0]  din_reg;

  logic accept_state;
  logic in_xfer;
  logic limit_hit;

  // Gating with rst keeps in_ready low while reset is held.
  assign accept_state = (state_reg == S_IDLE) || (state_reg == S_KEY) ||
                        (state_reg == S_DATA);
  assign in_ready     = accept_state && !rst;
  assign in_xfer      = in_valid && in_ready;
  assign limit_hit    = (cnt_reg == LIMIT);

  assign out_valid  = (state_reg == S_OUT);
  assign out_data   = out_data_reg;
  assign core_start = (state_reg == S_START);
  assign core_mode  = mode_reg;
  assign core_key   = key_reg;
  assign core_din   = din_reg;
  assign busy       = (state_reg != S_IDLE);
  assign err        = err_reg;

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (in_xfer) begin
          state_next = in_data[6] ? S_KEY : S_DATA;
        end
      end
      S_KEY: begin
        if (in_xfer && (key_idx_reg == 2'd3)) begin
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (in_xfer) begin
          state_next = S_START;
        end
      end
      S_START: begin
        state_next = S_BUSY;
      end
      S_BUSY: begin
        if (core_done) begin
          state_next = S_OUT;
        end else if (limit_hit) begin
          state_next = S_IDLE;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_next = (remain_reg == 4'd0) ? S_IDLE : S_DATA;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      remain_reg   <= 4'd0;
      key_idx_reg  <= 2'd0;
      cnt_reg      <= 8'd0;
      key_reg      <= 32'd0;
      mode_reg     <= 1'b0;
      err_reg      <= 1'b0;
      out_data_reg <= 8'd0;
      din_reg      <= 8'd0;
    end else begin
      state_reg <= state_next;
      unique case (state_reg)
        S_IDLE: begin
          if (in_xfer) begin
            mode_reg    <= in_data[7];
            remain_reg  <= in_data[3:0];
            key_idx_reg <= 2'd0;
            if (in_data[5]) begin
              err_reg <= 1'b0;
            end
          end
        end
        S_KEY: begin
          if (in_xfer) begin
            key_idx_reg <= key_idx_reg + 2'd1;
            // Commit the whole key at once so core_key never shows a mix
            // of old and new bytes.
            if (key_idx_reg == 2'd3) begin
              key_reg <= {in_data, key_shadow_reg[2], key_shadow_reg[1],
                          key_shadow_reg[0]};
            end
          end
        end
        S_DATA: begin
          if (in_xfer) begin
            din_reg <= in_data;
          end
        end
        S_START: begin
          cnt_reg <= 8'd0;
        end
        S_BUSY: begin
          if (core_done) begin
            out_data_reg <= core_dout;
          end else if (limit_hit) begin
            err_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        S_OUT: begin
          if (out_ready && (remain_reg != 4'd0)) begin
            remain_reg <= remain_reg - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Key shadow byte lanes, filled LSB first while in KEY
  for (genvar gi = 0; gi < 4; gi++) begin : g_key_lane
    always_ff @(posedge clk) begin
      if (rst) begin
        key_shadow_reg[gi] <= 8'd0;
      end else if ((state_reg == S_KEY) && in_xfer &&
                   (key_idx_reg == 2'(gi))) begin
        key_shadow_reg[gi] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_arith_crypt_seq.sv
// -----------------------------------------------------------------------------
// tb_arith_crypt_seq
//
// Self-checking bench for arith_crypt_seq (TIMEOUT = 8). A behavioural core
// answers each start pulse with din ^ 0xFF after a chosen latency, or never.
// Expected results come from the command rules: result = payload ^ 0xFF,
// the key is the last fully loaded key, and mode is taken from the header.
// -----------------------------------------------------------------------------
module tb_arith_crypt_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        core_start;
  logic        core_mode;
  logic [31:0] core_key;
  logic [7:0]  core_din;
  logic [7:0]  core_dout;
  logic        core_done;
  logic        busy;
  logic        err;

  int tests = 0;
  int fails = 0;

  arith_crypt_seq #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .core_start (core_start),
    .core_mode  (core_mode),
    .core_key   (core_key),
    .core_din   (core_din),
    .core_dout  (core_dout),
    .core_done  (core_done),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Behavioural cipher core
  int       core_lat  = 1;
  bit       core_hang = 1'b0;
  int       core_cd   = 0;
  logic [7:0] core_val = 8'd0;

  initial begin
    core_done = 1'b0;
    core_dout = 8'd0;
  end

  always @(posedge clk) begin
    core_done <= 1'b0;
    if (core_start === 1'b1 && !core_hang) begin
      core_cd  = core_lat;
      core_val = core_din ^ 8'hFF;
    end
    if (core_cd > 0) begin
      core_cd--;
      if (core_cd == 0) begin
        core_done <= 1'b1;
        core_dout <= core_val;
      end
    end
  end

  // Start pulse monitor
  int   start_cnt    = 0;
  int   start_double = 0;
  logic start_prev   = 1'b0;
  always @(negedge clk) begin
    if (core_start === 1'b1) begin
      start_cnt++;
      if (start_prev === 1'b1) start_double++;
    end
    start_prev = core_start;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input string tag, input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    $display("[TB] sent %s byte %02h", tag, b);
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp,
                           input logic mode, input int stall);
    int n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, out_data}, {24'd0, exp});
    check({tag, "_mode"}, {31'd0, core_mode}, {31'd0, mode});
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_hold"}, {22'd0, out_valid, in_ready, out_data},
            {22'd0, 1'b1, 1'b0, exp});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("[TB] recv %s byte %02h (expected %02h)", tag, out_data, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"},
          {24'd0, in_ready, out_valid, core_start, core_mode, busy, err, 2'b00},
          32'd0);
    check({tag, "_key"}, core_key, 32'd0);
    check({tag, "_bytes"}, {16'd0, core_din, out_data}, 32'd0);
  endtask

  logic [31:0] exp_key;
  logic [7:0]  pay;
  logic [7:0]  hdr;
  logic        m;
  logic        kl;
  logic [3:0]  len;
  int          s0;

  initial begin
    rst       = 1'b1;
    in_data   = 8'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_key   = 32'd0;

    // Reset state
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    #1;
    check("reset_release_ready", {31'd0, in_ready}, 32'd1);

    // Key load and encrypt, with exact latency of the first operation
    send_byte("hdr40", 8'h40);
    send_byte("key0", 8'h11);
    send_byte("key1", 8'h22);
    check("key_partial", core_key, 32'd0);
    send_byte("key2", 8'h33);
    send_byte("key3", 8'h44);
    exp_key = 32'h4433_2211;
    check("key_loaded", core_key, exp_key);
    send_byte("pay5a", 8'h5A);
    check("start_cycle", {23'd0, core_start, core_din}, {23'd0, 1'b1, 8'h5A});
    tick();
    check("busy_cycle", {30'd0, core_start, out_valid}, 32'd0);
    tick();
    check("out_valid_t3", {31'd0, out_valid}, 32'd1);
    recv_byte("enc", 8'hA5, 1'b0, 0);
    check("enc_idle", {31'd0, busy}, 32'd0);

    // Multi-byte decrypt with backpressure
    send_byte("hdr82", 8'h82);
    for (int i = 1; i <= 3; i++) begin
      pay = 8'(i);
      send_byte("dec_pay", pay);
      recv_byte("dec", pay ^ 8'hFF, 1'b1, 5);
      check("dec_busy", {31'd0, busy}, (i == 3) ? 32'd0 : 32'd1);
    end

    // Timeout: no core_done ever arrives
    core_hang = 1'b1;
    send_byte("hdr01", 8'h01);
    send_byte("to_pay", 8'h77);
    tick();                       // BUSY entered on this edge
    for (int i = 0; i < 7; i++) begin
      tick();
      check("to_wait", {30'd0, err, out_valid}, 32'd0);
    end
    tick();
    check("to_err", {29'd0, err, busy, out_valid}, {29'd0, 3'b100});
    check("to_idle_ready", {31'd0, in_ready}, 32'd1);
    core_hang = 1'b0;
    send_byte("hdr20", 8'h20);
    check("err_cleared", {31'd0, err}, 32'd0);
    send_byte("clr_pay", 8'h3C);
    recv_byte("clr", 8'hC3, 1'b0, 1);

    // core_done in the last permitted cycle counts as success
    core_lat = 8;
    send_byte("hdr00", 8'h00);
    send_byte("lim_pay", 8'h96);
    recv_byte("limit", 8'h69, 1'b0, 0);
    check("limit_err", {31'd0, err}, 32'd0);
    core_lat = 1;

    // 16-byte command, bit4 set (ignored)
    send_byte("hdr1f", 8'h1F);
    for (int i = 0; i < 16; i++) begin
      pay = 8'(i * 7 + 3);
      send_byte("long_pay", pay);
      recv_byte("long", pay ^ 8'hFF, 1'b0, 0);
    end
    check("long_done", {31'd0, busy}, 32'd0);

    // Reset in the middle of a key load
    send_byte("hdr40b", 8'h40);
    send_byte("rk0", 8'hAA);
    send_byte("rk1", 8'hBB);
    rst = 1'b1;
    tick();
    check_reset_outputs("mid_key_rst");
    rst = 1'b0;
    #1;
    exp_key = 32'd0;
    send_byte("hdr_after_rst", 8'h00);
    check("after_rst_busy", {31'd0, busy}, 32'd1);
    send_byte("rst_pay", 8'h33);
    recv_byte("after_rst", 8'hCC, 1'b0, 0);
    check("after_rst_key", core_key, exp_key);

    // Key persistence across commands
    send_byte("hdr40c", 8'h40);
    for (int i = 0; i < 4; i++) begin
      pay = 8'($urandom_range(0, 255));
      exp_key[i*8 +: 8] = pay;
      send_byte("pk", pay);
    end
    send_byte("pk_pay", 8'h01);
    recv_byte("pk", 8'hFE, 1'b0, 0);
    s0 = start_cnt;
    send_byte("hdr00b", 8'h00);
    send_byte("persist_pay", 8'h10);
    recv_byte("persist", 8'hEF, 1'b0, 2);
    check("persist_key", core_key, exp_key);
    check("persist_starts", 32'(start_cnt - s0), 32'd1);

    // Randomized commands against the command-level model
    for (int c = 0; c < 12; c++) begin
      m   = 1'($urandom_range(0, 1));
      kl  = 1'($urandom_range(0, 1));
      len = 4'($urandom_range(0, 3));
      hdr = {m, kl, 1'b0, 1'($urandom_range(0, 1)), len};
      send_byte("rnd_hdr", hdr);
      if (kl) begin
        for (int i = 0; i < 4; i++) begin
          pay = 8'($urandom_range(0, 255));
          exp_key[i*8 +: 8] = pay;
          send_byte("rnd_key", pay);
        end
      end
      for (int i = 0; i <= int'(len); i++) begin
        pay      = 8'($urandom_range(0, 255));
        core_lat = $urandom_range(1, 8);
        send_byte("rnd_pay", pay);
        recv_byte("rnd", pay ^ 8'hFF, m, $urandom_range(0, 3));
        check("rnd_key", core_key, exp_key);
      end
      check("rnd_idle", {30'd0, busy, err}, 32'd0);
    end

    check("start_single", start_double, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
